// File: rtl/byte_framer_pkg.sv
// byte_framer shared types and defaults.
// Imported by the framer and its idle timer.
package byte_framer_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 8;
  localparam int DEF_TO_W   = 8;
  localparam int DEF_FCNT_W = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/frm_idle_timer.sv
// Idle timer for the held byte of byte_framer.
// Pulses expire on the edge completing T idle cycles.
module frm_idle_timer
  import byte_framer_pkg::*;
#(
  parameter int TO_W = DEF_TO_W
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            active,
  input  logic            clr,
  input  logic [TO_W-1:0] timeout,
  output logic            expire
);

  logic [TO_W-1:0] t_q;
  logic [TO_W:0]   t_inc;

  assign t_inc = {1'b0, t_q} + 1'b1;

  assign expire = active
               && (timeout != '0)
               && (t_inc >= {1'b0, timeout});

  // Idle count: cleared on capture, saturates at timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q <= '0;
    end else if (clr) begin
      t_q <= '0;
    end else if (active && (t_q < timeout)) begin
      t_q <= t_q + 1'b1;
    end
  end

endmodule

// File: rtl/byte_framer.sv
// Byte stream framer: length/idle close, SOP/EOP,
// per-frame count and XOR checksum on the last byte.
module byte_framer
  import byte_framer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int TO_W   = DEF_TO_W,
  parameter int FCNT_W = DEF_FCNT_W
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  cfg_frm_len,
  input  logic [TO_W-1:0]   cfg_timeout,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop,
  output logic [LEN_W-1:0]  dout_cnt,
  output logic [DATA_W-1:0] dout_chk,
  output logic [FCNT_W-1:0] frm_cnt
);

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] hold_q;
  logic              last_q;
  logic              last_d;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_d;
  logic [LEN_W-1:0]  cnt_base;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [DATA_W-1:0] acc_base;
  logic [LEN_W-1:0]  len_eff;
  logic              sop_pend_q;
  logic              held;
  logic              expire;
  logic              emit;
  logic              emit_eop;

  assign held    = (state_q == S_HOLD);
  assign len_eff = (cfg_frm_len == '0)
                 ? LEN_W'(1) : cfg_frm_len;

  frm_idle_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (held),
    .clr     (din_vld),
    .timeout (cfg_timeout),
    .expire  (expire)
  );

  // Emission and frame-total bookkeeping for this edge.
  always_comb begin
    emit     = 1'b0;
    emit_eop = 1'b0;
    if (held) begin
      emit     = last_q || din_vld || expire;
      emit_eop = last_q || (!din_vld && expire);
    end
    cnt_base = emit_eop ? '0 : cnt_q;
    acc_base = emit_eop ? '0 : acc_q;
    cnt_d    = cnt_base;
    acc_d    = acc_base;
    last_d   = last_q;
    if (din_vld) begin
      cnt_d  = cnt_base + 1'b1;
      acc_d  = acc_base ^ din;
      last_d = (cnt_d >= len_eff);
    end
  end

  // Next-state: hold stays busy while bytes keep arriving.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (din_vld) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (din_vld)   state_d = S_HOLD;
        else if (emit) state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Hold register, frame totals and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= '0;
      last_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      sop_pend_q <= 1'b1;
      dout       <= '0;
      dout_vld   <= 1'b0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_cnt   <= '0;
      dout_chk   <= '0;
      frm_cnt    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      last_q   <= last_d;
      dout_vld <= emit;
      dout_sop <= emit && sop_pend_q;
      dout_eop <= emit_eop;
      if (din_vld) hold_q <= din;
      if (emit) begin
        dout       <= hold_q;
        dout_cnt   <= cnt_q;
        dout_chk   <= acc_q;
        sop_pend_q <= emit_eop;
      end
      if (emit_eop) frm_cnt <= frm_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_byte_framer.sv
// Self-checking bench for byte_framer.
// Frame-level queue model predicts every output cycle.
module tb_byte_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_frm_len;
  logic [7:0]  cfg_timeout;
  logic [7:0]  din;
  logic        din_vld;
  logic [7:0]  dout;
  logic        dout_vld;
  logic        dout_sop;
  logic        dout_eop;
  logic [7:0]  dout_cnt;
  logic [7:0]  dout_chk;
  logic [15:0] frm_cnt;

  byte_framer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_frm_len (cfg_frm_len),
    .cfg_timeout (cfg_timeout),
    .din         (din),
    .din_vld     (din_vld),
    .dout        (dout),
    .dout_vld    (dout_vld),
    .dout_sop    (dout_sop),
    .dout_eop    (dout_eop),
    .dout_cnt    (dout_cnt),
    .dout_chk    (dout_chk),
    .frm_cnt     (frm_cnt)
  );

  always #5 clk = ~clk;

  int chk_n = 0;
  int err_n = 0;
  int cyc_n = 0;

  // Reference model: bytes of the open frame, plus the held byte.
  logic [7:0]  frm_q[$];
  bit          m_held;
  bit          m_last;
  bit          m_sop;
  logic [7:0]  m_byte;
  int          m_idle;
  logic [15:0] m_frm;

  logic        e_vld, e_sop, e_eop;
  logic [7:0]  e_dat, e_cnt, e_chk;
  logic [15:0] e_frm;

  logic [42:0] act_w, exp_w;

  always_comb begin
    act_w = {dout_vld, dout_sop, dout_eop,
             e_vld ? dout : 8'h00,
             e_eop ? dout_cnt : 8'h00,
             e_eop ? dout_chk : 8'h00,
             frm_cnt};
    exp_w = {e_vld, e_sop, e_eop,
             e_vld ? e_dat : 8'h00,
             e_eop ? e_cnt : 8'h00,
             e_eop ? e_chk : 8'h00,
             e_frm};
  end

  function automatic void model_reset();
    frm_q.delete();
    m_held = 0; m_last = 0; m_sop = 1;
    m_byte = 0; m_idle = 0; m_frm = 0;
    e_vld = 0; e_sop = 0; e_eop = 0;
    e_dat = 0; e_cnt = 0; e_chk = 0; e_frm = 0;
  endfunction

  function automatic void model(bit v, logic [7:0] d);
    bit em, eo;
    int lim;
    em = 0; eo = 0;
    if (m_held) begin
      if (m_last) begin
        em = 1; eo = 1;
      end else if (v) begin
        em = 1;
      end else if (cfg_timeout != 0 &&
                   m_idle + 1 >= int'(cfg_timeout)) begin
        em = 1; eo = 1;
      end
    end
    e_vld = em; e_eop = eo; e_sop = em && m_sop;
    if (em) begin
      e_dat = m_byte;
      e_cnt = 8'(frm_q.size());
      e_chk = 8'h00;
      foreach (frm_q[i]) e_chk ^= frm_q[i];
      m_sop = eo;
    end
    if (eo) begin
      frm_q.delete();
      m_frm = m_frm + 16'd1;
    end
    e_frm = m_frm;
    if (v) begin
      frm_q.push_back(d);
      m_held = 1; m_byte = d; m_idle = 0;
      lim = (cfg_frm_len == 0) ? 1 : int'(cfg_frm_len);
      m_last = frm_q.size() >= lim;
    end else if (em) begin
      m_held = 0;
    end else if (m_held) begin
      m_idle++;
    end
  endfunction

  task automatic step(input bit v, input logic [7:0] d);
    din_vld = v;
    din     = d;
    @(posedge clk);
    model(v, d);
    #1;
    cyc_n++;
  endtask

  task automatic test_reset();
    chk_n++;
    if ({dout, dout_vld, dout_sop, dout_eop,
         dout_cnt, dout_chk, frm_cnt} !== 43'h0) begin
      err_n++;
      $display("FAIL reset_state got %h %b%b%b %h %h %h want all 0",
               dout, dout_vld, dout_sop, dout_eop,
               dout_cnt, dout_chk, frm_cnt);
    end
  endtask

  task automatic test_len4();
    int vcnt = 0;
    cfg_frm_len = 8'd4; cfg_timeout = 8'd0;
    for (int i = 1; i <= 11; i++) begin
      step(i <= 8, (i <= 8) ? 8'(i) : 8'h00);
      if (dout_vld) vcnt++;
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL len4 cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
      if (i == 5) begin
        chk_n++;
        if ({dout_eop, dout, dout_cnt, dout_chk} !==
            {1'b1, 8'h04, 8'd4, 8'h04}) begin
          err_n++;
          $display("FAIL len4_f1 got %b %h %0d %h want 1 04 4 04",
                   dout_eop, dout, dout_cnt, dout_chk);
        end
      end
    end
    chk_n++;
    if (vcnt != 8 || frm_cnt !== 16'd2) begin
      err_n++;
      $display("FAIL len4_totals got %0d bytes %0d frames want 8 2",
               vcnt, frm_cnt);
    end
  endtask

  task automatic test_timeout();
    int cap_c = 0;
    int eop_c = -1;
    logic [7:0] seq [3] = '{8'hA0, 8'hA1, 8'hA2};
    cfg_frm_len = 8'd16; cfg_timeout = 8'd5;
    for (int i = 0; i < 12; i++) begin
      step(i < 3, (i < 3) ? seq[i] : 8'h00);
      if (i == 2) cap_c = cyc_n;
      if (dout_vld && dout_eop) begin
        eop_c = cyc_n;
        chk_n++;
        if ({dout, dout_cnt, dout_chk} !==
            {8'hA2, 8'd3, 8'hA3}) begin
          err_n++;
          $display("FAIL timeout_eop got %h %0d %h want a2 3 a3",
                   dout, dout_cnt, dout_chk);
        end
      end
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL timeout cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
    end
    chk_n++;
    if (eop_c - cap_c != 5) begin
      err_n++;
      $display("FAIL timeout_lat got %0d want 5", eop_c - cap_c);
    end
  endtask

  task automatic test_gap();
    int eops = 0;
    cfg_frm_len = 8'd16; cfg_timeout = 8'd5;
    for (int i = 0; i < 16; i++) begin
      step(i == 0 || i == 5, 8'hB0 + 8'(i));
      if (dout_vld && dout_eop) eops++;
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL gap cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
    end
    chk_n++;
    if (eops != 1) begin
      err_n++;
      $display("FAIL gap_eops got %0d want 1", eops);
    end
  endtask

  task automatic test_expiry();
    cfg_frm_len = 8'd16; cfg_timeout = 8'd3;
    for (int i = 0; i < 10; i++) begin
      step(i == 0 || i == 3, (i == 0) ? 8'hC0 : 8'hC1);
      if (i == 3) begin
        chk_n++;
        if ({dout_vld, dout_eop, dout} !==
            {1'b1, 1'b0, 8'hC0}) begin
          err_n++;
          $display("FAIL expiry_race got %b %b %h want 1 0 c0",
                   dout_vld, dout_eop, dout);
        end
      end
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL expiry cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
    end
  endtask

  task automatic test_len1();
    cfg_frm_len = 8'd1; cfg_timeout = 8'd0;
    for (int i = 0; i < 16; i++) begin
      step($urandom_range(0, 1) == 1, 8'($urandom));
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL len1 cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
      if (dout_vld) begin
        chk_n++;
        if ({dout_sop, dout_eop, dout_cnt, dout_chk} !==
            {1'b1, 1'b1, 8'd1, dout}) begin
          err_n++;
          $display("FAIL len1_frame got %b%b %0d %h want 11 1 %h",
                   dout_sop, dout_eop, dout_cnt, dout_chk, dout);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    cfg_frm_len = 8'd4; cfg_timeout = 8'd0;
    step(1'b1, 8'hD0);
    step(1'b1, 8'hD1);
    #3 rst_n = 1'b0;
    #1;
    test_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      step(i < 4, 8'hE0 + 8'(i));
      if (i == 1) begin
        chk_n++;
        if ({dout_vld, dout_sop, dout, frm_cnt} !==
            {1'b1, 1'b1, 8'hE0, 16'd0}) begin
          err_n++;
          $display("FAIL rst_sop got %b%b %h %0d want 11 e0 0",
                   dout_vld, dout_sop, dout, frm_cnt);
        end
      end
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL rst_mid cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        cfg_frm_len = 8'($urandom_range(0, 6));
        cfg_timeout = 8'($urandom_range(0, 6));
      end
      step($urandom_range(0, 99) < 55, 8'($urandom));
      chk_n++;
      if (act_w !== exp_w) begin
        err_n++;
        $display("FAIL random cyc %0d got %h want %h",
                 cyc_n, act_w, exp_w);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    din         = 8'h00;
    din_vld     = 1'b0;
    cfg_frm_len = 8'd4;
    cfg_timeout = 8'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_len4();
    test_timeout();
    test_gap();
    test_expiry();
    test_len1();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             chk_n, err_n);
    $finish;
  end

endmodule
